// File: rtl/sdram_dma_pkg.sv
// Shared types and helpers for the SDRAM burst DMA block: FSM state
// encoding, default burst ceiling and the per-word test pattern.
package sdram_dma_pkg;

   localparam int DEFAULT_MAX_BURST = 16;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_REQ,
      RD_WAIT,
      DONE
   } dma_state_t;

   // Word w of a transfer carries its own index and its complement.
   function automatic logic [127:0] dma_pattern(input logic [63:0] w);
      return {~w, w};
   endfunction

endpackage

// File: rtl/sdram_dma_burst_sizer.sv
// Burst sizing: burstcount = min(burst length, words remaining) and the
// word count left once that burst is issued.
module sdram_dma_burst_sizer #(
   parameter int BURST_W = 8
) (
   input  logic [BURST_W-1:0] len,
   input  logic [31:0]        remaining,
   output logic [BURST_W-1:0] count,
   output logic [31:0]        left
);

   always_comb begin
      count = len;
      if (remaining < 32'(len)) begin
         count = BURST_W'(remaining);
      end
      left = remaining - 32'(count);
   end

endmodule

// File: rtl/sdram_burst_dma_ctrl.sv
// Avalon-MM SDRAM burst write (and optional readback verify) DMA engine.
// Optional readback is built in when SDRAM_DMA_READBACK_EN is defined.
module sdram_burst_dma_ctrl
   import sdram_dma_pkg::*;
#(
   parameter int ADDR_W    = 28,
   parameter int DATA_W    = 128,
   parameter int BURST_W   = 8,
   parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_stb_i,
   input  logic [31:0]         base_addr_i,
   input  logic [31:0]         size_i,
   input  logic [BURST_W-1:0]  burst_len_i,
   output logic                busy_o,
   output logic                done_stb_o,
   output logic [31:0]         cycle_cnt_o,
   output logic [31:0]         err_cnt_o,
   output logic [ADDR_W-1:0]   sdram_address_o,
   output logic [BURST_W-1:0]  sdram_burstcount_o,
   output logic [DATA_W-1:0]   sdram_writedata_o,
   output logic [DATA_W/8-1:0] sdram_byteenable_o,
   output logic                sdram_write_o,
   output logic                sdram_read_o,
   input  logic                sdram_waitrequest_i,
   input  logic [DATA_W-1:0]   sdram_readdata_i,
   input  logic                sdram_readdatavalid_i
);

   dma_state_t         state;
   logic [BURST_W-1:0] eff_in;
   logic [BURST_W-1:0] eff_r;
   logic [BURST_W-1:0] sz_len;
   logic [BURST_W-1:0] sz_count;
   logic [BURST_W-1:0] bc_r;
   logic [BURST_W-1:0] beat;
   logic [31:0]        rem;
   logic [31:0]        sz_rem;
   logic [31:0]        sz_left;
   logic [63:0]        widx;
   logic               last_beat;

`ifdef SDRAM_DMA_READBACK_EN
   logic               rd_r;
   logic [31:0]        err_r;
   logic [ADDR_W-1:0]  base_r;
   logic [31:0]        size_r;

   assign sdram_read_o = rd_r;
   assign err_cnt_o    = err_r;
`else
   logic               unused_rd;

   assign sdram_read_o = 1'b0;
   assign err_cnt_o    = '0;
   assign unused_rd    = ^{sdram_readdata_i, sdram_readdatavalid_i};
`endif

   assign sdram_byteenable_o = '1;

   always_comb begin
      eff_in = burst_len_i;
      if (burst_len_i == '0) begin
         eff_in = BURST_W'(1);
      end else if (32'(burst_len_i) > 32'(MAX_BURST)) begin
         eff_in = BURST_W'(MAX_BURST);
      end
   end

   // In IDLE the sizer sees the incoming request so the first burst issues
   // on the start edge; afterwards it sees the words not yet issued.
   assign sz_len    = (state == IDLE) ? eff_in : eff_r;
   assign sz_rem    = (state == IDLE) ? size_i : rem;
   assign last_beat = (beat == bc_r - BURST_W'(1));

   sdram_dma_burst_sizer #(
      .BURST_W(BURST_W)
   ) u_sizer (
      .len      (sz_len),
      .remaining(sz_rem),
      .count    (sz_count),
      .left     (sz_left)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= IDLE;
         busy_o             <= 1'b0;
         done_stb_o         <= 1'b0;
         cycle_cnt_o        <= '0;
         sdram_address_o    <= '0;
         sdram_burstcount_o <= '0;
         sdram_writedata_o  <= '0;
         sdram_write_o      <= 1'b0;
         eff_r              <= '0;
         bc_r               <= '0;
         beat               <= '0;
         rem                <= '0;
         widx               <= '0;
`ifdef SDRAM_DMA_READBACK_EN
         rd_r               <= 1'b0;
         err_r              <= '0;
         base_r             <= '0;
         size_r             <= '0;
`endif
      end else begin
         if (busy_o && cycle_cnt_o != '1) begin
            cycle_cnt_o <= cycle_cnt_o + 32'd1;
         end
         case (state)
            IDLE: begin
               if (start_stb_i) begin
                  eff_r           <= eff_in;
                  cycle_cnt_o     <= '0;
                  busy_o          <= 1'b1;
                  widx            <= '0;
                  beat            <= '0;
                  sdram_address_o <= ADDR_W'(base_addr_i);
`ifdef SDRAM_DMA_READBACK_EN
                  err_r           <= '0;
                  base_r          <= ADDR_W'(base_addr_i);
                  size_r          <= size_i;
`endif
                  if (size_i == '0) begin
                     state      <= DONE;
                     done_stb_o <= 1'b1;
                  end else begin
                     state              <= WR;
                     sdram_write_o      <= 1'b1;
                     sdram_burstcount_o <= sz_count;
                     bc_r               <= sz_count;
                     rem                <= sz_left;
                     sdram_writedata_o  <= DATA_W'(dma_pattern('0));
                  end
               end
            end
            WR: begin
               if (!sdram_waitrequest_i) begin
                  widx              <= widx + 64'd1;
                  sdram_writedata_o <= DATA_W'(dma_pattern(widx + 64'd1));
                  if (!last_beat) begin
                     beat <= beat + BURST_W'(1);
                  end else begin
                     beat <= '0;
                     if (rem == '0) begin
                        sdram_write_o <= 1'b0;
`ifdef SDRAM_DMA_READBACK_EN
                        state           <= RD_REQ;
                        sdram_address_o <= base_r;
                        rem             <= size_r;
                        widx            <= '0;
`else
                        state      <= DONE;
                        done_stb_o <= 1'b1;
`endif
                     end else begin
                        sdram_address_o    <= sdram_address_o + ADDR_W'(bc_r);
                        sdram_burstcount_o <= sz_count;
                        bc_r               <= sz_count;
                        rem                <= sz_left;
                     end
                  end
               end
            end
`ifdef SDRAM_DMA_READBACK_EN
            RD_REQ: begin
               if (!rd_r) begin
                  rd_r               <= 1'b1;
                  sdram_burstcount_o <= sz_count;
                  bc_r               <= sz_count;
                  rem                <= sz_left;
               end else if (!sdram_waitrequest_i) begin
                  rd_r  <= 1'b0;
                  beat  <= '0;
                  state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (sdram_readdatavalid_i) begin
                  if (sdram_readdata_i != DATA_W'(dma_pattern(widx)) && err_r != '1) begin
                     err_r <= err_r + 32'd1;
                  end
                  widx <= widx + 64'd1;
                  if (!last_beat) begin
                     beat <= beat + BURST_W'(1);
                  end else begin
                     beat            <= '0;
                     sdram_address_o <= sdram_address_o + ADDR_W'(bc_r);
                     if (rem == '0) begin
                        state      <= DONE;
                        done_stb_o <= 1'b1;
                     end else begin
                        state <= RD_REQ;
                     end
                  end
               end
            end
`endif
            DONE: begin
               done_stb_o <= 1'b0;
               busy_o     <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sdram_burst_dma_ctrl.md
SDRAM_BURST_DMA_CTRL -- requirements
Module: sdram_burst_dma_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 28, SDRAM port word-address width.
  DATA_W, 128, SDRAM port data width.
  BURST_W, 8, burstcount width.
  MAX_BURST, 16, largest burst issued, in words.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
  clk_i  in  1  single clock.
  rst_i  in  1  reset, synchronous, active-high.
  start_stb_i  in  1  one-cycle start pulse.
  base_addr_i  in  32  first word address.
  size_i  in  32  transfer length in words.
  burst_len_i  in  BURST_W  requested burst length.
  busy_o  out  1  transfer in progress.
  done_stb_o  out  1  one-cycle completion pulse, also used as the IRQ.
  cycle_cnt_o  out  32  cycles from start to done.
  err_cnt_o  out  32  readback mismatches.
  sdram_address_o  out  ADDR_W  Avalon-MM address.
  sdram_burstcount_o  out  BURST_W  Avalon-MM burstcount.
  sdram_writedata_o  out  DATA_W  Avalon-MM write data.
  sdram_byteenable_o  out  DATA_W/8  Avalon-MM byteenable, all ones.
  sdram_write_o  out  1  Avalon-MM write.
  sdram_read_o  out  1  Avalon-MM read.
  sdram_waitrequest_i  in  1  Avalon-MM waitrequest.
  sdram_readdata_i  in  DATA_W  Avalon-MM read data.
  sdram_readdatavalid_i  in  1  Avalon-MM read data valid.

Function
REQ-003 The state machine SHALL have the states IDLE, WR, RD_REQ, RD_WAIT and DONE.
REQ-004 In IDLE, start_stb_i SHALL latch base_addr_i, size_i and the effective burst length, clear cycle_cnt_o and err_cnt_o, and go to WR, or to DONE when size_i is 0.
REQ-005 The effective burst length SHALL be burst_len_i, with 0 replaced by 1 and values above MAX_BURST clamped to MAX_BURST.
REQ-006 Each burst's burstcount SHALL be min(effective burst length, remaining words); the address SHALL advance by burstcount after the burst's last beat.
REQ-007 Write beats: a beat is accepted when sdram_write_o=1 and sdram_waitrequest_i=0; while waitrequest is high, address, burstcount and data SHALL be held stable.
REQ-008 Write data SHALL be {~w, w}, where w is the 64-bit index of the word within the transfer, counting from 0.
REQ-009 busy_o SHALL be 1 in every state except IDLE; cycle_cnt_o SHALL increment every cycle busy_o=1 and saturate at 0xFFFFFFFF.
REQ-010 DONE SHALL last exactly one cycle, assert done_stb_o and return to IDLE.
REQ-011 start_stb_i while busy_o=1 SHALL be ignored.
REQ-012 sdram_write_o and sdram_read_o SHALL never both be 1.

Reset
REQ-013 rst_i SHALL, on the next clock edge, force IDLE and zero every output, including during an active burst; the partial burst is abandoned.
REQ-014 A start_stb_i that coincides with rst_i SHALL be ignored.

Configuration
REQ-015 Macro SDRAM_DMA_READBACK_EN: when defined, WR goes to RD_REQ after its last beat; when undefined, WR goes directly to DONE.
REQ-016 With SDRAM_DMA_READBACK_EN, RD_REQ SHALL issue a read burst (sizing as REQ-006), held until waitrequest is low; RD_WAIT SHALL accept burstcount readdatavalid beats.
REQ-017 With SDRAM_DMA_READBACK_EN, each returned beat SHALL be compared with the REQ-008 pattern and err_cnt_o incremented on mismatch, saturating; after the last burst the block goes to DONE, otherwise back to RD_REQ.
REQ-018 Without SDRAM_DMA_READBACK_EN, sdram_read_o and err_cnt_o SHALL be tied to 0.

Structure
REQ-019 Package sdram_dma_pkg SHALL hold the state enum, the MAX_BURST default and the pattern function.
REQ-020 Sub-module sdram_dma_burst_sizer SHALL compute the burstcount and the remaining-word count.

Verification
REQ-021 size=40, burst_len=16, no waitrequest -> bursts of 16, 16 and 8 at base, base+16 and base+32; done_stb_o pulses once.
REQ-022 size=0 -> done_stb_o one cycle after start; no write or read issued; cycle_cnt_o=1.
REQ-023 Random waitrequest, size=5, burst_len=0 -> five bursts of 1; data stable while stalled; word 3 = {~64'd3, 64'd3}.
REQ-024 READBACK_EN defined, size=32, beat 7 corrupted by the model -> err_cnt_o=1 at done.
REQ-025 rst_i mid-burst -> next cycle sdram_write_o=0 and busy_o=0; a new start completes normally.
